// File: rtl/synth_pkg.sv
// Shared types and constants for the synth's PWM receive path.
package synth_pkg;

    localparam int unsigned PWM_W = 8;

    typedef enum logic [1:0] {
        HUNT,
        ACQ,
        LOCK
    } pwm_dec_state_t;

endpackage

// File: rtl/pwm_decoder_if.sv
// Decoded sample stream: sample, its valid strobe and the lock/alignment status.
interface pwm_decoder_if #(
    parameter int unsigned W = synth_pkg::PWM_W
) ();

    logic [W-1:0] sample_out;
    logic         sample_valid;
    logic         locked;
    logic         sync_err;

    modport master (
        output sample_out,
        output sample_valid,
        output locked,
        output sync_err
    );

    modport slave (
        input sample_out,
        input sample_valid,
        input locked,
        input sync_err
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detect.
module sync_edge (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;

endmodule

// File: rtl/pwm_decoder.sv
// Recovers W-bit samples from a 1-bit PWM stream by counting high clocks per 2**W-clock
// frame, with frame alignment tracked by a HUNT/ACQ/LOCK state machine.
module pwm_decoder
    import synth_pkg::*;
#(
    parameter int unsigned W = PWM_W
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          enable,
    input  logic          pwm_in,
    pwm_decoder_if.master dec
);

    localparam logic [W-1:0] FCNT_MAX = {W{1'b1}};
    localparam logic [W:0]   HCNT_SAT = {1'b0, {W{1'b1}}};
    localparam logic [W-1:0] FCNT_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W:0]   HCNT_ONE = {{W{1'b0}}, 1'b1};

    pwm_dec_state_t state_q, state_d;
    logic [W-1:0]   fcnt_q, fcnt_d;
    logic [W:0]     hcnt_q, hcnt_d;
    logic [W-1:0]   sample_q, sample_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic           locked_q;

    logic           s2;
    logic           rise;
    logic           frame_end;
    logic [W:0]     hsum;

    sync_edge u_sync_edge (
        .clk  (clk),
        .n_rst(n_rst),
        .d    (pwm_in),
        .q    (s2),
        .rise (rise)
    );

    // High count including the current cycle; at frame end this is the frame's duty.
    assign hsum      = hcnt_q + {{W{1'b0}}, s2};
    assign frame_end = (state_q != HUNT) && (fcnt_q == FCNT_MAX);

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q + 1'b1;
        hcnt_d   = hsum;
        sample_d = sample_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        if (!enable) begin
            state_d = HUNT;
            fcnt_d  = '0;
            hcnt_d  = '0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    fcnt_d = '0;
                    hcnt_d = '0;
                    if (rise) begin
                        state_d = ACQ;
                    end
                end
                ACQ, LOCK: begin
                    if (frame_end) begin
                        valid_d  = 1'b1;
                        sample_d = (hsum > HCNT_SAT) ? FCNT_MAX : hsum[W-1:0];
                        hcnt_d   = '0;
                        state_d  = LOCK;
                    end
                end
                default: state_d = HUNT;
            endcase

            // The rise cycle is frame index 0, so the next cycle is index 1.
            if (rise) begin
                fcnt_d = FCNT_ONE;
                hcnt_d = HCNT_ONE;
                if (state_q == LOCK && fcnt_q != '0) begin
                    err_d   = 1'b1;
                    state_d = ACQ;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= HUNT;
            fcnt_q   <= '0;
            hcnt_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            hcnt_q   <= hcnt_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            locked_q <= (state_d == LOCK);
        end
    end

    assign dec.sample_out   = sample_q;
    assign dec.sample_valid = valid_q;
    assign dec.locked       = locked_q;
    assign dec.sync_err     = err_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: PWM frames with random duties, checked every cycle against a
// frame-level model built from the recorded input history.
module tb_pwm_decoder;
    import synth_pkg::*;

    localparam int FL     = 256;
    localparam int MAXS   = 255;
    localparam int NCYC   = 16384;
    localparam int M_HUNT = 0;
    localparam int M_ACQ  = 1;
    localparam int M_LOCK = 2;

    logic clk    = 1'b0;
    logic n_rst  = 1'b0;
    logic enable = 1'b1;
    logic pwm_in = 1'b0;

    pwm_decoder_if #(.W(PWM_W)) dec_if ();

    pwm_decoder #(.W(PWM_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .enable(enable),
        .pwm_in(pwm_in),
        .dec   (dec_if)
    );

    always #5 clk = ~clk;

    bit   p_hist  [NCYC];
    bit   en_hist [NCYC];
    int   cyc      = 0;
    int   m_mode   = M_HUNT;
    int   m_start  = 0;
    int   m_sample = 0;
    logic exp_valid  = 1'b0;
    logic exp_err    = 1'b0;
    logic exp_locked = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [10:0] obs();
        return {dec_if.sample_valid, dec_if.sync_err, dec_if.locked, dec_if.sample_out};
    endfunction

    function automatic logic [10:0] expv();
        return {exp_valid, exp_err, exp_locked, 8'(m_sample)};
    endfunction

    // Expected outputs after clock edge cyc. A pwm_in value driven after edge i is acted
    // on at edge i+3; enable driven after edge cyc-1 is seen at edge cyc.
    task automatic model_edge();
        int  i;
        int  pos;
        int  sum;
        int  old_mode;
        bit  rise;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (!n_rst) begin
            m_mode     = M_HUNT;
            m_sample   = 0;
            exp_locked = 1'b0;
            return;
        end
        i = cyc - 3;
        if (i < 1 || !en_hist[cyc-1]) begin
            m_mode     = M_HUNT;
            exp_locked = 1'b0;
            return;
        end
        rise     = p_hist[i] && !p_hist[i-1];
        old_mode = m_mode;
        if (old_mode == M_HUNT) begin
            if (rise) begin
                m_mode  = M_ACQ;
                m_start = i;
            end
        end else begin
            pos = (i - m_start) % FL;
            if (pos == FL - 1) begin
                sum = 0;
                for (int k = i - FL + 1; k <= i; k++) sum += int'(p_hist[k]);
                m_sample  = (sum > MAXS) ? MAXS : sum;
                exp_valid = 1'b1;
                m_mode    = M_LOCK;
            end
            if (rise) begin
                if (old_mode == M_LOCK && pos != 0) begin
                    exp_err = 1'b1;
                    m_mode  = M_ACQ;
                end
                m_start = i;
            end
        end
        exp_locked = (m_mode == M_LOCK);
    endtask

    // One clock: update the model for this edge, drive inputs, return on the falling edge.
    task automatic drive(input bit pv, input bit ev);
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        pwm_in       = pv;
        enable       = ev;
        p_hist[cyc]  = pv;
        en_hist[cyc] = ev;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int nv = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1);
            n_cmp++;
            if (obs() !== 11'd0) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got=%h want=%h", cyc, obs(), 11'd0);
            end
        end
        n_rst = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            drive(1'b0, 1'b1);
            if (dec_if.sample_valid) nv++;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL idle_cycle cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        n_cmp++;
        if (nv != 0) begin
            n_bad++;
            $display("FAIL idle_valid_count got=%0d want=0", nv);
        end
        n_cmp++;
        if ({dec_if.locked, dec_if.sample_out} !== 9'd0) begin
            n_bad++;
            $display("FAIL idle_state got=%h want=0", {dec_if.locked, dec_if.sample_out});
        end
    endtask

    task automatic test_lock();
        int e0 = -1;
        int first_v = -1;
        int nv = 0;
        int last = -1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < FL; k++) begin
                drive(k < 100, 1'b1);
                if (e0 < 0) e0 = cyc;
                if (dec_if.sample_valid) begin
                    nv++;
                    last = int'(dec_if.sample_out);
                    if (first_v < 0) first_v = cyc;
                end
                n_cmp++;
                if (obs() !== expv()) begin
                    n_bad++;
                    $display("FAIL lock_cycle cyc=%0d got=%h want=%h", cyc, obs(), expv());
                end
            end
        end
        n_cmp++;
        if (first_v != e0 + 258) begin
            n_bad++;
            $display("FAIL lock_first_valid got=%0d want=%0d", first_v, e0 + 258);
        end
        n_cmp++;
        if (nv != 2 || last != 100) begin
            n_bad++;
            $display("FAIL lock_samples got=%0d/%0d want=2/100", nv, last);
        end
        n_cmp++;
        if (dec_if.locked !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_locked got=%b want=1", dec_if.locked);
        end
    endtask

    task automatic test_zero_duty();
        int nv = 0;
        int ne = 0;
        int last = -1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FL; k++) begin
                drive(1'b0, 1'b1);
                if (dec_if.sample_valid) begin
                    nv++;
                    last = int'(dec_if.sample_out);
                end
                if (dec_if.sync_err) ne++;
                n_cmp++;
                if (obs() !== expv()) begin
                    n_bad++;
                    $display("FAIL zero_cycle cyc=%0d got=%h want=%h", cyc, obs(), expv());
                end
            end
        end
        n_cmp++;
        if (nv != 2 || last != 0 || ne != 0) begin
            n_bad++;
            $display("FAIL zero_samples got=%0d/%0d/%0d want=2/0/0", nv, last, ne);
        end
        n_cmp++;
        if (dec_if.locked !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_locked got=%b want=1", dec_if.locked);
        end
    endtask

    task automatic test_early_rise();
        int d = int'($urandom_range(1, 200));
        int ne = 0;
        int nv_after = 0;
        int last = -1;
        logic err_lock = 1'bx;
        for (int k = 0; k < FL - 40; k++) begin
            drive(k < 50, 1'b1);
            if (dec_if.sync_err) begin
                ne++;
                err_lock = dec_if.locked;
            end
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL early_cycle cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FL; k++) begin
                drive(k < d, 1'b1);
                if (dec_if.sync_err) begin
                    ne++;
                    err_lock = dec_if.locked;
                end
                if (ne > 0 && dec_if.sample_valid) begin
                    nv_after++;
                    last = int'(dec_if.sample_out);
                end
                n_cmp++;
                if (obs() !== expv()) begin
                    n_bad++;
                    $display("FAIL early_cycle cyc=%0d got=%h want=%h", cyc, obs(), expv());
                end
            end
        end
        n_cmp++;
        if (ne != 1 || err_lock !== 1'b0) begin
            n_bad++;
            $display("FAIL early_sync_err got=%0d/%b want=1/0", ne, err_lock);
        end
        n_cmp++;
        if (nv_after != 1 || last != d || dec_if.locked !== 1'b1) begin
            n_bad++;
            $display("FAIL early_relock got=%0d/%0d/%b want=1/%0d/1", nv_after, last,
                     dec_if.locked, d);
        end
    endtask

    task automatic test_saturate();
        int ne = 0;
        int nsat = 0;
        for (int k = 0; k < 3 * FL; k++) begin
            drive(k < 600, 1'b1);
            if (dec_if.sync_err) ne++;
            if (dec_if.sample_valid && dec_if.sample_out == 8'd255) nsat++;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL sat_cycle cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        n_cmp++;
        if (nsat != 2 || ne != 0) begin
            n_bad++;
            $display("FAIL sat_samples got=%0d/%0d want=2/0", nsat, ne);
        end
    endtask

    task automatic test_random_frames();
        int nv = 0;
        int ne = 0;
        int d;
        for (int f = 0; f < 6; f++) begin
            d = int'($urandom_range(0, FL));
            for (int k = 0; k < FL; k++) begin
                drive(k < d, 1'b1);
                if (dec_if.sample_valid) nv++;
                if (dec_if.sync_err) ne++;
                n_cmp++;
                if (obs() !== expv()) begin
                    n_bad++;
                    $display("FAIL rand_cycle cyc=%0d duty=%0d got=%h want=%h", cyc, d, obs(),
                             expv());
                end
            end
        end
        n_cmp++;
        if (nv != 6 || ne != 0 || dec_if.locked !== 1'b1) begin
            n_bad++;
            $display("FAIL rand_summary got=%0d/%0d/%b want=6/0/1", nv, ne, dec_if.locked);
        end
    endtask

    task automatic test_abort();
        int nv = 0;
        int last = -1;
        for (int k = 0; k < 128; k++) begin
            drive(k < 60, 1'b1);
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL abort_cycle cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        n_rst = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 11'd0) begin
            n_bad++;
            $display("FAIL abort_reset got=%h want=%h", obs(), 11'd0);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1);
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL abort_cycle cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        n_rst = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FL; k++) begin
                drive(k < 30, 1'b1);
                if (dec_if.sample_valid) begin
                    nv++;
                    last = int'(dec_if.sample_out);
                end
                n_cmp++;
                if (obs() !== expv()) begin
                    n_bad++;
                    $display("FAIL abort_cycle cyc=%0d got=%h want=%h", cyc, obs(), expv());
                end
            end
        end
        n_cmp++;
        if (nv != 1 || last != 30) begin
            n_bad++;
            $display("FAIL abort_relock got=%0d/%0d want=1/30", nv, last);
        end
        for (int k = 0; k < 128; k++) begin
            drive(k < 45, 1'b1);
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL abort_cycle cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        nv = 0;
        for (int k = 0; k < 128 + FL; k++) begin
            drive((k >= 128) && (k - 128 < 45), 1'b0);
            if (dec_if.sample_valid) nv++;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL disable_cycle cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        n_cmp++;
        if (nv != 0 || dec_if.sample_out !== 8'd30 || dec_if.locked !== 1'b0) begin
            n_bad++;
            $display("FAIL disable_hold got=%0d/%0d/%b want=0/30/0", nv, dec_if.sample_out,
                     dec_if.locked);
        end
        nv = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FL; k++) begin
                drive(k < 45, 1'b1);
                if (dec_if.sample_valid) begin
                    nv++;
                    last = int'(dec_if.sample_out);
                end
                n_cmp++;
                if (obs() !== expv()) begin
                    n_bad++;
                    $display("FAIL reenable_cycle cyc=%0d got=%h want=%h", cyc, obs(), expv());
                end
            end
        end
        n_cmp++;
        if (nv != 1 || last != 45 || dec_if.locked !== 1'b1) begin
            n_bad++;
            $display("FAIL reenable_relock got=%0d/%0d/%b want=1/45/1", nv, last,
                     dec_if.locked);
        end
    endtask

    initial begin
        en_hist[0] = 1'b1;
        p_hist[0]  = 1'b0;
        test_reset();
        test_lock();
        test_zero_duty();
        test_early_rise();
        test_saturate();
        test_random_frames();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
